// File: rtl/seq_pkg.sv
// Shared definitions for the LED state sequencer: display state codes,
// the run-control FSM encoding and the default step period.
// Pure declarations, no logic.
package seq_pkg;

    // Display state codes, matching the display block's state decode.
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    // Run-control FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } run_st_e;

    // One step per second at 50 MHz.
    localparam int TICK_DIV_DEFAULT = 50000000;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when d_i goes 0 -> 1.
// Latency: combinational pulse in the cycle d_i is first seen high.
// Backpressure: none.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Remember last cycle's input level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/led_state_sequencer.sv
// Display state sequencer: walks S0..S(NUM_STATES-1) once per TICK_DIV cycles
// under start/pause control; blink is a divided 50% phase. All outputs registered.
// No backpressure. Optional: SEQ_AUTOSTOP_EN stops after one full lap.
module led_state_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int NUM_STATES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       in,
    output logic [2:0] state,
    output logic       blink,
    output logic       step_pulse,
    output logic       running
);

    localparam int             DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [2:0]     ST_LAST  = 3'(NUM_STATES - 1);

    logic start_rise;
    logic pause_rise;

    run_st_e          fsm_q, fsm_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       state_q, state_d;
    logic             blink_q, blink_d;
    logic             step_q, step_d;
    logic             running_q;
    logic             advance;
    logic             step_tick;
    logic             fresh_start;
    logic [2:0]       state_next;

    rise_detect u_start_rise (
        .clk_i  (clk),
        .rst_i  (reset),
        .d_i    (start),
        .rise_o (start_rise)
    );

    rise_detect u_pause_rise (
        .clk_i  (clk),
        .rst_i  (reset),
        .d_i    (pause),
        .rise_o (pause_rise)
    );

    // The divider only moves in RUN cycles that are not being paused,
    // so a pause freezes the phase exactly where it was.
    assign advance   = (fsm_q == RUN) && !pause_rise;
    assign step_tick = advance && (div_cnt_q == DIV_LAST);

    // Next display state; direction is only looked at on the step cycle.
    always_comb begin
        state_next = state_q;
        if (in) begin
            state_next = (state_q == S0) ? ST_LAST : state_q - 3'd1;
        end else begin
            state_next = (state_q == ST_LAST) ? S0 : state_q + 3'd1;
        end
    end

`ifdef SEQ_AUTOSTOP_EN
    // Steps taken since the last entry from IDLE; survives pause/resume.
    logic [3:0] steps_q, steps_d;
    logic       lap_done;

    assign lap_done = step_tick && (steps_q == 4'(NUM_STATES - 1));

    // Lap step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps_q <= 4'd0;
        end else begin
            steps_q <= steps_d;
        end
    end

    // Clear on a fresh start or lap end, bump on each step.
    always_comb begin
        steps_d = steps_q;
        if (fresh_start || lap_done) begin
            steps_d = 4'd0;
        end else if (step_tick) begin
            steps_d = steps_q + 4'd1;
        end
    end
`else
    logic lap_done;

    assign lap_done = 1'b0;
`endif

    // Run FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Run FSM next state: pause beats a simultaneous start.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (start_rise && !pause_rise) begin
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (pause_rise) begin
                    fsm_d = PAUSED;
                end else if (lap_done) begin
                    fsm_d = IDLE;
                end
            end
            PAUSED: begin
                if (start_rise && !pause_rise) begin
                    fsm_d = RUN;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign fresh_start = (fsm_q == IDLE) && (fsm_d == RUN);

    // Divider, blink phase and display state next values.
    always_comb begin
        div_cnt_d = div_cnt_q;
        state_d   = state_q;
        blink_d   = blink_q;
        step_d    = 1'b0;
        if (fresh_start) begin
            div_cnt_d = '0;
            state_d   = S0;
            blink_d   = 1'b0;
        end else if (advance) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
            if ((div_cnt_q == DIV_HALF) || (div_cnt_q == DIV_LAST)) begin
                blink_d = ~blink_q;
            end
            if (step_tick) begin
                step_d  = 1'b1;
                state_d = state_next;
            end
            if (lap_done) begin
                blink_d = 1'b0;
            end
        end
    end

    // Datapath and output registers; running trails the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            state_q   <= S0;
            blink_q   <= 1'b0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            blink_q   <= blink_d;
            step_q    <= step_d;
            running_q <= (fsm_q == RUN);
        end
    end

    assign state      = state_q;
    assign blink      = blink_q;
    assign step_pulse = step_q;
    assign running    = running_q;

endmodule

// File: tb/tb_led_state_sequencer.sv
// Testbench for led_state_sequencer with TICK_DIV = 4, NUM_STATES = 6.
// Directed scenarios followed by random start/pause/direction traffic,
// all checked cycle by cycle against a time-based reference model.
module tb_led_state_sequencer;

    localparam int TD = 4;
    localparam int NS = 6;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       in_s;
    logic [2:0] state;
    logic       blink;
    logic       step_pulse;
    logic       running;

    int n_chk;
    int n_bad;

    // Reference model: elapsed run time since fresh start drives everything.
    int m_mode;
    int m_elapsed;
    int m_state;
    int m_blink;
    int m_step;
    int m_running;
    int m_nsteps;
    int m_ps;
    int m_pp;

    led_state_sequencer #(
        .TICK_DIV   (TD),
        .NUM_STATES (NS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .in         (in_s),
        .state      (state),
        .blink      (blink),
        .step_pulse (step_pulse),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_elapsed = 0;
        m_state   = 0;
        m_blink   = 0;
        m_step    = 0;
        m_running = 0;
        m_nsteps  = 0;
        m_ps      = 0;
        m_pp      = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".state"},   int'(state),      m_state);
        chk({tag, ".blink"},   int'(blink),      m_blink);
        chk({tag, ".step"},    int'(step_pulse), m_step);
        chk({tag, ".running"}, int'(running),    m_running);
    endtask

    // One clock: apply inputs, advance the model at the edge, compare at negedge.
    task automatic tick(input logic s, input logic p, input logic d);
        int sr;
        int pr;
        int was_run;
        start = s;
        pause = p;
        in_s  = d;
        @(posedge clk);
        sr      = (s && m_ps == 0) ? 1 : 0;
        pr      = (p && m_pp == 0) ? 1 : 0;
        m_ps    = int'(s);
        m_pp    = int'(p);
        was_run = (m_mode == M_RUN) ? 1 : 0;
        m_step  = 0;
        if (m_mode == M_IDLE) begin
            if (sr == 1 && pr == 0) begin
                m_mode    = M_RUN;
                m_elapsed = 0;
                m_state   = 0;
                m_blink   = 0;
                m_nsteps  = 0;
            end
        end else if (m_mode == M_PAUSED) begin
            if (sr == 1 && pr == 0) m_mode = M_RUN;
        end else begin
            if (pr == 1) begin
                m_mode = M_PAUSED;
            end else begin
                m_elapsed++;
                m_blink = ((m_elapsed % TD) >= TD / 2) ? 1 : 0;
                if (m_elapsed % TD == 0) begin
                    m_step   = 1;
                    m_state  = d ? (m_state + NS - 1) % NS : (m_state + 1) % NS;
                    m_nsteps++;
`ifdef SEQ_AUTOSTOP_EN
                    if (m_nsteps == NS) begin
                        m_mode  = M_IDLE;
                        m_blink = 0;
                    end
`endif
                end
            end
        end
        m_running = was_run;
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic idle_ticks(input int n, input logic d);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, d);
    endtask

    // Async reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        start = 1'b0;
        pause = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        check_outputs("arst_hold");
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        model_reset();
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        in_s  = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;

        // Forward lap and beyond.
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(26, 1'b0);
        // Reverse from the current position.
        idle_ticks(10, 1'b1);

        // Pause mid-interval, hold, resume.
        async_reset();
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(6, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        idle_ticks(10, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(8, 1'b0);

        // Start and pause together while running, then resume.
        tick(1'b1, 1'b1, 1'b0);
        idle_ticks(4, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(3, 1'b0);

        // Start and pause together from IDLE.
        async_reset();
        tick(1'b1, 1'b1, 1'b0);
        idle_ticks(6, 1'b0);

        // Reset mid-interval at state 3, then nothing until a new start.
        async_reset();
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(13, 1'b0);
        async_reset();
        idle_ticks(20, 1'b0);

        // Full lap with one pause/resume in the middle.
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(9, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        idle_ticks(5, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(30, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0) ? ~in_s : in_s);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
